// File: rtl/regfile_pkg.sv
// regfile_pkg: shared write-source encoding and default register file geometry
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic WB_SRC_PC4 = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write-back and reservation bus of the register file
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     wr_sel;
  logic [DATA_W-1:0]        wr_pc4;
  logic [DATA_W-1:0]        wr_mem;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [2**ADDR_W-1:0]     busy_vec;
  logic [ADDR_W:0]          pend_cnt;
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_sel, wr_pc4, wr_mem, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec, pend_cnt
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_sel, wr_pc4, wr_mem, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec, pend_cnt
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with set-over-clear priority and live count
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rsv_en,
  input  logic [ADDR_W-1:0]    i_rsv_addr,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  output logic [2**ADDR_W-1:0] o_busy_next,
  output logic [2**ADDR_W-1:0] o_busy_vec,
  output logic [ADDR_W:0]      o_pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = ADDR_W + 1;
  logic [DEPTH-1:0] r_busy, w_set, w_clr;
  logic [CW-1:0]    r_cnt;
  logic             w_inc, w_dec;
  // a reservation beats a write-back on the same register: a new producer is in flight
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_rsv_en && !(ZERO_REG != 0 && i_rsv_addr == '0)) w_set[i_rsv_addr] = 1'b1;
    if (i_wr_en) w_clr[i_wr_addr] = 1'b1;
    o_busy_next = (r_busy & ~w_clr) | w_set;
    w_inc = |(w_set & ~r_busy);
    w_dec = |(w_clr & r_busy & ~w_set);
  end
  // busy bits and their population count move together each edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= o_busy_next;
      r_cnt  <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  assign o_busy_vec = r_busy;
  assign o_pend_cnt = r_cnt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write-back mux, bypass and RAW scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd [NUM_RD];
  logic [NUM_RD-1:0] r_rb;
  logic [DEPTH-1:0]  w_busy_next, w_busy_vec;
  logic [ADDR_W:0]   w_pend_cnt;
  logic [DATA_W-1:0] w_wd;
  logic              w_wr_ok;
  assign w_wd = (bus.wr_sel == WB_SRC_MEM) ? bus.wr_mem : bus.wr_pc4;
  assign w_wr_ok = bus.wr_en && !(ZR && bus.wr_addr == '0);
  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_rsv_en   (bus.rsv_en),
    .i_rsv_addr (bus.rsv_addr),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .o_busy_next(w_busy_next),
    .o_busy_vec (w_busy_vec),
    .o_pend_cnt (w_pend_cnt)
  );
  // register storage; writes to the hardwired zero register are dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    else if (w_wr_ok) r_mem[bus.wr_addr] <= w_wd;
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    assign w_ra = bus.rd_addr[g*ADDR_W +: ADDR_W];
    assign w_rd = (ZR && w_ra == '0) ? '0 :
                  (BP && w_wr_ok && w_ra == bus.wr_addr) ? w_wd : r_mem[w_ra];
    // registered read data and busy flag, held while the port is idle
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_rd[g] <= '0;
        r_rb[g] <= 1'b0;
      end else if (bus.rd_en[g]) begin
        r_rd[g] <= w_rd;
        r_rb[g] <= w_busy_next[w_ra];
      end
  end
  // pack per-port results onto the bus
  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) bus.rd_data[p*DATA_W +: DATA_W] = r_rd[p];
  end
  assign bus.rd_busy  = r_rb;
  assign bus.busy_vec = w_busy_vec;
  assign bus.pend_cnt = w_pend_cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus reset/saturation sequences on bypass and no-bypass instances
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bp ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) nb ();
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_bp (
    .clk(clk), .rst(rst), .bus(bp));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .bus(nb));
  assign nb.rd_en = bp.rd_en;
  assign nb.rd_addr = bp.rd_addr;
  assign nb.wr_en = bp.wr_en;
  assign nb.wr_addr = bp.wr_addr;
  assign nb.wr_sel = bp.wr_sel;
  assign nb.wr_pc4 = bp.wr_pc4;
  assign nb.wr_mem = bp.wr_mem;
  assign nb.rsv_en = bp.rsv_en;
  assign nb.rsv_addr = bp.rsv_addr;
  typedef struct {
    logic [1:0]  re;
    logic [4:0]  a0, a1;
    logic        we;
    logic [4:0]  wa;
    logic        ws;
    logic [31:0] pc4, mem;
    logic        rv;
    logic [4:0]  ra;
    logic [31:0] d0, d1, d0n, d1n;
    logic [1:0]  rb;
    logic [5:0]  pc;
    logic [31:0] bv;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] re, input logic [4:0] a0, a1, input logic we,
                       input logic [4:0] wa, input logic ws, input logic [31:0] pc4, mem,
                       input logic rv, input logic [4:0] ra);
    bp.rd_en = re;
    bp.rd_addr = {a1, a0};
    bp.wr_en = we;
    bp.wr_addr = wa;
    bp.wr_sel = ws;
    bp.wr_pc4 = pc4;
    bp.wr_mem = mem;
    bp.rsv_en = rv;
    bp.rsv_addr = ra;
  endtask
  task automatic chk_all(input string t, input logic [31:0] d0, d1, d0n, d1n,
                         input logic [1:0] rb, input logic [5:0] pc, input logic [31:0] bv);
    chk({t, " bp.d0"}, 64'(bp.rd_data[31:0]), 64'(d0));
    chk({t, " bp.d1"}, 64'(bp.rd_data[63:32]), 64'(d1));
    chk({t, " nb.d0"}, 64'(nb.rd_data[31:0]), 64'(d0n));
    chk({t, " nb.d1"}, 64'(nb.rd_data[63:32]), 64'(d1n));
    chk({t, " bp.rb"}, 64'(bp.rd_busy), 64'(rb));
    chk({t, " nb.rb"}, 64'(nb.rd_busy), 64'(rb));
    chk({t, " bp.pc"}, 64'(bp.pend_cnt), 64'(pc));
    chk({t, " nb.pc"}, 64'(nb.pend_cnt), 64'(pc));
    chk({t, " bp.bv"}, 64'(bp.busy_vec), 64'(bv));
    chk({t, " nb.bv"}, 64'(nb.busy_vec), 64'(bv));
  endtask
  initial begin
    v[0]  = '{2'b00, 5'd0, 5'd0, 1, 5'd5, 1, 32'h0, 32'hDEADBEEF, 0, 5'd0,
              32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0};
    v[1]  = '{2'b01, 5'd5, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0,
              32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 6'd0, 32'h0};
    v[2]  = '{2'b00, 5'd0, 5'd0, 1, 5'd6, 0, 32'h404, 32'hAAAA5555, 0, 5'd0,
              32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 6'd0, 32'h0};
    v[3]  = '{2'b01, 5'd6, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0,
              32'h404, 32'h0, 32'h404, 32'h0, 2'b00, 6'd0, 32'h0};
    v[4]  = '{2'b11, 5'd7, 5'd7, 1, 5'd7, 1, 32'h0, 32'h12345678, 0, 5'd0,
              32'h12345678, 32'h12345678, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0};
    v[5]  = '{2'b11, 5'd0, 5'd0, 1, 5'd0, 1, 32'h0, 32'hFFFFFFFF, 1, 5'd0,
              32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0};
    v[6]  = '{2'b11, 5'd0, 5'd7, 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0,
              32'h0, 32'h12345678, 32'h0, 32'h12345678, 2'b00, 6'd0, 32'h0};
    v[7]  = '{2'b00, 5'd0, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 1, 5'd3,
              32'h0, 32'h12345678, 32'h0, 32'h12345678, 2'b00, 6'd1, 32'h8};
    v[8]  = '{2'b11, 5'd3, 5'd9, 0, 5'd0, 0, 32'h0, 32'h0, 1, 5'd9,
              32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 6'd2, 32'h208};
    v[9]  = '{2'b01, 5'd3, 5'd9, 1, 5'd3, 1, 32'h0, 32'h33333333, 1, 5'd3,
              32'h33333333, 32'h0, 32'h0, 32'h0, 2'b11, 6'd2, 32'h208};
    v[10] = '{2'b10, 5'd3, 5'd9, 1, 5'd9, 0, 32'h99, 32'h0, 0, 5'd0,
              32'h33333333, 32'h99, 32'h0, 32'h0, 2'b01, 6'd1, 32'h8};
    v[11] = '{2'b01, 5'd3, 5'd9, 0, 5'd0, 0, 32'h0, 32'h0, 1, 5'd3,
              32'h33333333, 32'h99, 32'h33333333, 32'h0, 2'b01, 6'd1, 32'h8};
    v[12] = '{2'b11, 5'd3, 5'd10, 1, 5'd3, 1, 32'h0, 32'h44444444, 1, 5'd10,
              32'h44444444, 32'h0, 32'h33333333, 32'h0, 2'b10, 6'd1, 32'h400};
    v[13] = '{2'b00, 5'd3, 5'd10, 1, 5'd12, 1, 32'h0, 32'hC, 0, 5'd0,
              32'h44444444, 32'h0, 32'h33333333, 32'h0, 2'b10, 6'd1, 32'h400};
    v[14] = '{2'b00, 5'd12, 5'd3, 1, 5'd10, 1, 32'h0, 32'h55, 0, 5'd0,
              32'h44444444, 32'h0, 32'h33333333, 32'h0, 2'b10, 6'd0, 32'h0};
    v[15] = '{2'b11, 5'd12, 5'd10, 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0,
              32'hC, 32'h55, 32'hC, 32'h55, 2'b00, 6'd0, 32'h0};
    drive(2'b00, 5'd0, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0);
    @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(v[i].re, v[i].a0, v[i].a1, v[i].we, v[i].wa, v[i].ws, v[i].pc4, v[i].mem,
            v[i].rv, v[i].ra);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), v[i].d0, v[i].d1, v[i].d0n, v[i].d1n, v[i].rb,
              v[i].pc, v[i].bv);
    end
    for (int a = 0; a < 32; a++) begin
      drive(2'b01, 5'(a), 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 1, 5'(a));
      @(posedge clk);
      #1;
    end
    drive(2'b00, 5'd0, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0);
    chk("sat bp.pc", 64'(bp.pend_cnt), 64'd31);
    chk("sat bp.bv", 64'(bp.busy_vec), 64'hFFFFFFFE);
    chk("sat bp.rb", 64'(bp.rd_busy), 64'h1);
    chk("sat nb.pc", 64'(nb.pend_cnt), 64'd31);
    rst = 1'b1;
    #1;
    chk_all("async rst", 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0);
    drive(2'b00, 5'd0, 5'd0, 1, 5'd20, 1, 32'h0, 32'hBAD, 1, 5'd21);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("rst edge", 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      drive(2'b11, 5'(a), 5'(31 - a), 0, 5'd0, 0, 32'h0, 32'h0, 0, 5'd0);
      @(posedge clk);
      #1;
      chk_all($sformatf("clr%0d", a), 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
